coder_quad_core: RTL

- Quadrature-encoder processing core of the coder IP. It sits directly downstream of the AXI4-Lite slave register bank.
- Consumes the control and preset registers written over S00_AXI, and returns position, index-capture and status values, which the register bank exposes for read-back.
- Decodes A/B/Z encoder pins into a signed 4x position count, with synchronisation, glitch filtering, index capture and illegal-transition detection.

---
 rtl/coder_quad_core.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/coder_quad_core.sv
// coder_quad_core: quadrature decoder. Turns the asynchronous A/B/Z pins into
// a signed 4x position count with synchronisation, glitch filtering, index
// capture and illegal-transition detection.
module coder_quad_core #(
   parameter int CNT_WIDTH   = 32,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic                 enc_a,
   input  logic                 enc_b,
   input  logic                 enc_z,
   input  logic                 ctrl_en,
   input  logic                 ctrl_dir_inv,
   input  logic                 ctrl_idx_clr_en,
   input  logic                 ctrl_clr,
   input  logic                 preset_load,
   input  logic [CNT_WIDTH-1:0] preset_val,
   input  logic                 idx_ack,
   input  logic                 err_clr,
   output logic [CNT_WIDTH-1:0] pos_cnt,
   output logic [CNT_WIDTH-1:0] idx_pos,
   output logic                 idx_valid,
   output logic                 err_flag,
   output logic                 dir_out,
   output logic                 primed
);

   localparam int SW = $clog2(FILT_LEN);
   localparam logic [SW-1:0] STAB_MAX = SW'(FILT_LEN - 1);
   localparam logic [SW-1:0] STAB_PRE = SW'(FILT_LEN - 2);

   // Gray phase {A,B} to a 2-bit position so a step is a modulo-4 difference.
   function automatic logic [1:0] gray_to_bin(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   // Pin index: 0 = A, 1 = B, 2 = Z.
   logic [2:0]             pin_s;
   logic [SYNC_STAGES-1:0] sync_q [3];
   // vld_q marks sync stages (and the sample-history flop) that hold real
   // post-reset samples, so the first filter window starts from a clean slate.
   logic [SYNC_STAGES:0]   vld_q;
   logic [2:0]             smp_s, same_s, samp_q, filt_q, filt_d, load_s;
   logic [SW-1:0]          stab_q [3];
   logic [SW-1:0]          stab_d [3];
   logic                   primed_q, primed_d;
   logic [1:0]             prev_q, prev_d, ab_s, delta_s;
   logic                   zprev_q, zprev_d;
   logic                   fwd_s, rev_s, illegal_s, idx_s, step_neg_s;
   logic [CNT_WIDTH-1:0]   pos_q, pos_d, idx_pos_q, idx_pos_d;
   logic                   idx_valid_q, idx_valid_d, err_q, err_d, dir_q, dir_d;

   assign pin_s = {enc_z, enc_b, enc_a};

   // Synchroniser chains plus the sample-valid shift register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < 3; i++) sync_q[i] <= '0;
         vld_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pin_s[i]};
         vld_q <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // Synchronised sample of each pin and whether it matches the previous one.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         smp_s[i]  = sync_q[i][SYNC_STAGES-1];
         same_s[i] = vld_q[SYNC_STAGES] && (samp_q[i] == sync_q[i][SYNC_STAGES-1]);
      end
   end

   // Stability counters: accept a new pin level once it has been steady long enough.
   always_comb begin
      filt_d = filt_q;
      load_s = 3'b000;
      for (int i = 0; i < 3; i++) begin
         stab_d[i] = stab_q[i];
         if (!vld_q[SYNC_STAGES-1]) begin
            stab_d[i] = stab_q[i];
         end else if (!same_s[i]) begin
            stab_d[i] = '0;
         end else if (stab_q[i] != STAB_MAX) begin
            stab_d[i] = stab_q[i] + SW'(1);
            if (stab_q[i] == STAB_PRE) begin
               load_s[i] = 1'b1;
               filt_d[i] = smp_s[i];
            end else begin
               load_s[i] = 1'b0;
            end
         end else begin
            stab_d[i] = stab_q[i];
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         samp_q <= 3'b000;
         filt_q <= 3'b000;
         for (int i = 0; i < 3; i++) stab_q[i] <= '0;
      end else begin
         samp_q <= smp_s;
         filt_q <= filt_d;
         for (int i = 0; i < 3; i++) stab_q[i] <= stab_d[i];
      end
   end

   // Step decode against the previous filtered phase, plus index-edge detect.
   always_comb begin
      ab_s      = {filt_q[0], filt_q[1]};
      delta_s   = gray_to_bin(ab_s) - gray_to_bin(prev_q);
      fwd_s     = 1'b0;
      rev_s     = 1'b0;
      illegal_s = 1'b0;
      if (primed_q) begin
         case (delta_s)
            2'd1:    fwd_s     = 1'b1;
            2'd3:    rev_s     = 1'b1;
            2'd2:    illegal_s = 1'b1;
            default: fwd_s     = 1'b0;
         endcase
      end else begin
         fwd_s = 1'b0;
      end
      step_neg_s = rev_s ^ ctrl_dir_inv;
      idx_s      = primed_q & ctrl_en & filt_q[2] & ~zprev_q & filt_q[0] & filt_q[1];
      primed_d   = primed_q | (|load_s);
      // While priming, history tracks the freshly loaded values so the first
      // accepted state never looks like a transition.
      if (primed_q) begin
         prev_d  = ab_s;
         zprev_d = filt_q[2];
      end else begin
         prev_d  = {filt_d[0], filt_d[1]};
         zprev_d = filt_d[2];
      end
   end

   // Counter priority, index capture and sticky error flag.
   always_comb begin
      pos_d       = pos_q;
      dir_d       = dir_q;
      idx_pos_d   = idx_pos_q;
      idx_valid_d = idx_valid_q;
      err_d       = err_q;
      if (ctrl_clr) begin
         pos_d = '0;
      end else if (idx_s && ctrl_idx_clr_en) begin
         pos_d = '0;
      end else if (preset_load) begin
         pos_d = preset_val;
      end else if (ctrl_en && (fwd_s || rev_s)) begin
         pos_d = step_neg_s ? (pos_q - CNT_WIDTH'(1)) : (pos_q + CNT_WIDTH'(1));
         dir_d = step_neg_s;
      end else begin
         pos_d = pos_q;
      end
      if (idx_s) begin
         idx_pos_d   = pos_q;
         idx_valid_d = 1'b1;
      end else if (idx_ack) begin
         idx_valid_d = 1'b0;
      end else begin
         idx_valid_d = idx_valid_q;
      end
      if (illegal_s && ctrl_en) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Decoder and output registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         primed_q    <= 1'b0;
         prev_q      <= 2'b00;
         zprev_q     <= 1'b0;
         pos_q       <= '0;
         dir_q       <= 1'b0;
         idx_pos_q   <= '0;
         idx_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         primed_q    <= primed_d;
         prev_q      <= prev_d;
         zprev_q     <= zprev_d;
         pos_q       <= pos_d;
         dir_q       <= dir_d;
         idx_pos_q   <= idx_pos_d;
         idx_valid_q <= idx_valid_d;
         err_q       <= err_d;
      end
   end

   assign pos_cnt   = pos_q;
   assign idx_pos   = idx_pos_q;
   assign idx_valid = idx_valid_q;
   assign err_flag  = err_q;
   assign dir_out   = dir_q;
   assign primed    = primed_q;

endmodule
